// File: rtl/weight_accum_select.sv
// Connect-6 move picker: accumulates scanner weights into a 19x19 saturating score
// grid and sweeps the board for the highest-scoring empty cell on request.
module weight_accum_select (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       wrEn,
  input  logic [4:0] wrX,
  input  logic [4:0] wrY,
  input  logic [3:0] wrWeight,
  input  logic       enaSelect,
  input  logic [1:0] boardData,
  output logic       boardRead,
  output logic [4:0] boardX,
  output logic [4:0] boardY,
  output logic       busy,
  output logic       doneSelect,
  output logic       moveValid,
  output logic [4:0] moveX,
  output logic [4:0] moveY,
  output logic [7:0] bestScore
);

  localparam int         NCELL      = 361;
  localparam logic [4:0] LAST_COORD = 5'd18;
  localparam logic [8:0] LAST_IDX   = 9'd360;
  localparam logic [1:0] EMPTY      = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, READ = 2'd2} state_t;

  // Code 8 is a forced win/threat marker; codes above it carry no weight.
  function automatic logic [7:0] accum(input logic [7:0] old, input logic [3:0] code);
    logic [8:0] inc;
    logic [8:0] sum;
    case (code)
      4'd0:    inc = 9'd1;
      4'd1:    inc = 9'd2;
      4'd2:    inc = 9'd4;
      4'd3:    inc = 9'd8;
      4'd4:    inc = 9'd16;
      4'd5:    inc = 9'd3;
      4'd6:    inc = 9'd12;
      4'd7:    inc = 9'd48;
      default: inc = 9'd0;
    endcase
    sum = {1'b0, old} + inc;
    if (code == 4'd8) begin
      accum = 8'hFF;
    end else if (sum[8]) begin
      accum = 8'hFF;
    end else begin
      accum = sum[7:0];
    end
  endfunction

  state_t     state_q, state_d;
  logic [4:0] x_q, x_d, y_q, y_d;
  logic [8:0] idx_q, idx_d;
  logic       found_q, found_d;
  logic       board_read_q, board_read_d;
  logic [4:0] board_x_q, board_x_d, board_y_q, board_y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       move_valid_q, move_valid_d;
  logic [4:0] move_x_q, move_x_d, move_y_q, move_y_d;
  logic [7:0] best_q, best_d;
  logic [7:0] score_q [NCELL];

  logic [8:0] wr_idx_s;
  logic       wr_ok_s, wr_s, clr_s, cand_s;
  logic [7:0] cur_score_s;

  assign wr_idx_s    = ({4'd0, wrY} * 9'd19) + {4'd0, wrX};
  assign wr_ok_s     = (wrX <= LAST_COORD) && (wrY <= LAST_COORD);
  assign cur_score_s = score_q[idx_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCELL; i++) score_q[i] <= 8'd0;
    end else if (clr_s) begin
      for (int i = 0; i < NCELL; i++) score_q[i] <= 8'd0;
    end else if (wr_s) begin
      score_q[wr_idx_s] <= accum(score_q[wr_idx_s], wrWeight);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= 5'd0;
      y_q          <= 5'd0;
      idx_q        <= 9'd0;
      found_q      <= 1'b0;
      board_read_q <= 1'b0;
      board_x_q    <= 5'd0;
      board_y_q    <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      move_valid_q <= 1'b0;
      move_x_q     <= 5'd0;
      move_y_q     <= 5'd0;
      best_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      found_q      <= found_d;
      board_read_q <= board_read_d;
      board_x_q    <= board_x_d;
      board_y_q    <= board_y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      move_valid_q <= move_valid_d;
      move_x_q     <= move_x_d;
      move_y_q     <= move_y_d;
      best_q       <= best_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    idx_d        = idx_q;
    found_d      = found_q;
    board_read_d = board_read_q;
    board_x_d    = board_x_q;
    board_y_d    = board_y_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    move_valid_d = move_valid_q;
    move_x_d     = move_x_q;
    move_y_d     = move_y_q;
    best_d       = best_q;
    clr_s        = 1'b0;
    wr_s         = 1'b0;
    cand_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          clr_s = 1'b1;
        end else begin
          wr_s = wrEn && wr_ok_s;
          if (enaSelect) begin
            state_d      = ADDR;
            x_d          = 5'd0;
            y_d          = 5'd0;
            idx_d        = 9'd0;
            found_d      = 1'b0;
            move_valid_d = 1'b0;
            busy_d       = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ADDR: begin
        board_read_d = 1'b1;
        board_x_d    = x_q;
        board_y_d    = y_q;
        state_d      = READ;
      end
      READ: begin
        // Strict compare keeps the earliest cell on ties.
        cand_s = (boardData == EMPTY) && (!found_q || (cur_score_s > best_q));
        if (cand_s) begin
          move_x_d = x_q;
          move_y_d = y_q;
          best_d   = cur_score_s;
          found_d  = 1'b1;
        end else begin
          found_d = found_q;
        end
        if (idx_q == LAST_IDX) begin
          board_read_d = 1'b0;
          move_valid_d = found_q | cand_s;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = ADDR;
          if (x_q == LAST_COORD) begin
            x_d = 5'd0;
            y_d = y_q + 5'd1;
          end else begin
            x_d = x_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign boardRead  = board_read_q;
  assign boardX     = board_x_q;
  assign boardY     = board_y_q;
  assign busy       = busy_q;
  assign doneSelect = done_q;
  assign moveValid  = move_valid_q;
  assign moveX      = move_x_q;
  assign moveY      = move_y_q;
  assign bestScore  = best_q;

endmodule

// File: tb/tb_weight_accum_select.sv
// Randomized bench for weight_accum_select: a score-grid model and an argmax
// over empty cells predict every selection result and its timing.
module tb_weight_accum_select;

  logic       clk = 1'b0;
  logic       reset, clear, wrEn, enaSelect;
  logic [4:0] wrX, wrY;
  logic [3:0] wrWeight;
  logic [1:0] boardData;
  logic       boardRead, busy, doneSelect, moveValid;
  logic [4:0] boardX, boardY, moveX, moveY;
  logic [7:0] bestScore;

  weight_accum_select dut (
    .clk(clk), .reset(reset), .clear(clear), .wrEn(wrEn), .wrX(wrX), .wrY(wrY),
    .wrWeight(wrWeight), .enaSelect(enaSelect), .boardData(boardData),
    .boardRead(boardRead), .boardX(boardX), .boardY(boardY), .busy(busy),
    .doneSelect(doneSelect), .moveValid(moveValid), .moveX(moveX), .moveY(moveY),
    .bestScore(bestScore)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         model [361];
  logic [1:0] brd [361];
  int         inc_tab [8] = '{1, 2, 4, 8, 16, 3, 12, 48};
  int         exp_valid, exp_x, exp_y, exp_best;
  int         bidx;

  // Board memory: data follows the registered address.
  always_comb begin
    bidx = int'(boardY) * 19 + int'(boardX);
    if (boardRead && bidx < 361) boardData = brd[bidx];
    else boardData = 2'd3;
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int acc(input int old, input int code);
    int s;
    if (code == 8) return 255;
    if (code > 8) return old;
    s = old + inc_tab[code];
    return (s > 255) ? 255 : s;
  endfunction

  function automatic void model_write(input int x, input int y, input int c);
    if (x < 19 && y < 19) model[y*19+x] = acc(model[y*19+x], c);
  endfunction

  function automatic void model_clear();
    foreach (model[i]) model[i] = 0;
  endfunction

  function automatic void fill_board(input int v);
    foreach (brd[i]) brd[i] = 2'(v);
  endfunction

  // Argmax over empty cells, first occurrence wins; previous move held otherwise.
  function automatic void ref_select();
    int best = -1;
    int bk = -1;
    for (int k = 0; k < 361; k++)
      if (brd[k] == 2'd2 && model[k] > best) begin
        best = model[k];
        bk = k;
      end
    exp_valid = (bk >= 0);
    if (bk >= 0) begin
      exp_x = bk % 19;
      exp_y = bk / 19;
      exp_best = best;
    end
  endfunction

  task automatic do_write(input int x, input int y, input int c);
    @(negedge clk);
    clear = 1'b0; enaSelect = 1'b0; wrEn = 1'b1;
    wrX = 5'(x); wrY = 5'(y); wrWeight = 4'(c);
    @(posedge clk);
    model_write(x, y, c);
  endtask

  task automatic do_clear(input bit co_wr, input int x, input int y, input int c);
    @(negedge clk);
    clear = 1'b1; enaSelect = 1'b0; wrEn = co_wr;
    wrX = 5'(x); wrY = 5'(y); wrWeight = 4'(c);
    @(posedge clk);
    model_clear();
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    clear = 1'b0; wrEn = 1'b0; enaSelect = 1'b0;
  endtask

  task automatic run_select(input string tag, input bit co_wr, input int cx, input int cy, input int cc);
    int done_off, rd_rise, rd_fall, busy_fall, addr_err, k;
    done_off = -1; rd_rise = -1; rd_fall = -1; busy_fall = -1; addr_err = 0;
    @(negedge clk);
    clear = 1'b0; enaSelect = 1'b1; wrEn = co_wr;
    wrX = 5'(cx); wrY = 5'(cy); wrWeight = 4'(cc);
    @(posedge clk);
    if (co_wr) model_write(cx, cy, cc);
    ref_select();
    #1;
    chk_eq({tag, ".busy_start"}, int'(busy), 1);
    chk_eq({tag, ".valid_cleared"}, int'(moveValid), 0);
    @(negedge clk);
    enaSelect = 1'b0; wrEn = 1'b0;
    for (int off = 1; off <= 1000; off++) begin
      @(posedge clk);
      #1;
      if (rd_rise < 0 && boardRead) rd_rise = off;
      if (rd_rise >= 0 && rd_fall < 0 && !boardRead) rd_fall = off;
      if (busy_fall < 0 && !busy) busy_fall = off;
      if ((off % 2) == 1 && off <= 721) begin
        k = (off - 1) / 2;
        if (int'(boardX) != k % 19 || int'(boardY) != k / 19 || !boardRead) addr_err++;
      end
      // Requests while busy must be dropped.
      if (off == 100) begin
        wrEn = 1'b1; wrX = 5'($urandom_range(0, 18)); wrY = 5'($urandom_range(0, 18));
        wrWeight = 4'd8; clear = 1'b1;
      end
      if (off == 150) enaSelect = 1'b1;
      if (off == 101 || off == 151) begin
        wrEn = 1'b0; clear = 1'b0; enaSelect = 1'b0;
      end
      if (done_off >= 0 && off == done_off + 1) begin
        chk_eq({tag, ".done_one_cycle"}, int'(doneSelect), 0);
        break;
      end
      if (done_off < 0 && doneSelect) done_off = off;
    end
    chk_eq({tag, ".done_edge"}, done_off, 722);
    chk_eq({tag, ".read_rise"}, rd_rise, 1);
    chk_eq({tag, ".read_fall"}, rd_fall, 722);
    chk_eq({tag, ".busy_fall"}, busy_fall, 722);
    chk_eq({tag, ".addr_seq_errs"}, addr_err, 0);
    chk_eq({tag, ".moveValid"}, int'(moveValid), exp_valid);
    chk_eq({tag, ".moveX"}, int'(moveX), exp_x);
    chk_eq({tag, ".moveY"}, int'(moveY), exp_y);
    chk_eq({tag, ".bestScore"}, int'(bestScore), exp_best);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, ".boardRead"}, int'(boardRead), 0);
    chk_eq({tag, ".boardXY"}, int'({boardX, boardY}), 0);
    chk_eq({tag, ".busy"}, int'(busy), 0);
    chk_eq({tag, ".done"}, int'(doneSelect), 0);
    chk_eq({tag, ".moveValid"}, int'(moveValid), 0);
    chk_eq({tag, ".moveXY"}, int'({moveX, moveY}), 0);
    chk_eq({tag, ".bestScore"}, int'(bestScore), 0);
  endtask

  initial begin
    int dones;
    reset = 1'b0; clear = 1'b0; wrEn = 1'b0; enaSelect = 1'b0;
    wrX = 5'd0; wrY = 5'd0; wrWeight = 4'd0;
    model_clear(); fill_board(2);
    exp_valid = 0; exp_x = 0; exp_y = 0; exp_best = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    run_select("empty", 1'b0, 0, 0, 0);

    do_write(3, 4, 2); do_write(3, 4, 2); do_write(10, 10, 4);
    idle_inputs();
    run_select("basic", 1'b0, 0, 0, 0);

    do_clear(1'b0, 0, 0, 0);
    do_write(7, 7, 8); do_write(7, 7, 0);
    for (int i = 0; i < 16; i++) do_write(1, 1, 4);
    idle_inputs();
    run_select("sat_tie", 1'b0, 0, 0, 0);

    do_clear(1'b0, 0, 0, 0);
    do_write(10, 10, 4); do_write(2, 2, 2);
    idle_inputs();
    brd[10*19+10] = 2'd0;
    run_select("occupied", 1'b0, 0, 0, 0);

    fill_board(1);
    run_select("all_white", 1'b0, 0, 0, 0);

    fill_board(2);
    do_clear(1'b0, 0, 0, 0);
    do_write(19, 0, 4); do_write(0, 19, 4); do_write(0, 0, 9);
    do_clear(1'b1, 5, 5, 7);
    idle_inputs();
    run_select("ignored", 1'b0, 0, 0, 0);

    run_select("wr_with_sel", 1'b1, 3, 3, 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 19) == 0) do_clear(1'b0, 0, 0, 0);
        else do_write($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 15));
      end
      idle_inputs();
      foreach (brd[i]) brd[i] = ($urandom_range(0, 3) < r) ? 2'($urandom_range(0, 3)) : 2'd2;
      run_select($sformatf("rand%0d", r), r[0], $urandom_range(0, 18), $urandom_range(0, 18),
                 $urandom_range(0, 15));
    end

    // Reset in the middle of a sweep aborts without a completion pulse.
    @(negedge clk);
    enaSelect = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enaSelect = 1'b0;
    repeat (299) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    model_clear(); fill_board(2);
    exp_valid = 0; exp_x = 0; exp_y = 0; exp_best = 0;
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (800) begin
      @(posedge clk);
      #1;
      if (doneSelect) dones++;
    end
    chk_eq("mid_rst.no_done", dones, 0);
    run_select("after_rst", 1'b0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
